// File: rtl/lsu_mem_pkg.sv
// Shared definitions for the load/store unit: FSM encoding and byte-lane decode constants.
package lsu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam int          LANE_BITS = 8;
    localparam int          NUM_LANES = 4;
    localparam logic [3:0]  BE_WORD   = 4'b1111;
    localparam logic [3:0]  BE_LANE0  = 4'b0001;

    // One-hot byte enable for the lane selected by the low address bits.
    function automatic logic [3:0] lane_be(input logic [1:0] off);
        return BE_LANE0 << off;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store byte enables, store data replication and load byte extraction.
module lsu_lane
    import lsu_mem_pkg::*;
(
    input  logic        wr_byte,
    input  logic [1:0]  wr_off,
    input  logic [31:0] wr_data,
    output logic [3:0]  be,
    output logic [31:0] wr_lanes,
    input  logic        rd_byte,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rd_raw,
    output logic [31:0] rd_data
);

    logic [LANE_BITS-1:0] rd_sel;

    always_comb begin
        be       = wr_byte ? lane_be(wr_off) : BE_WORD;
        wr_lanes = wr_byte ? {NUM_LANES{wr_data[LANE_BITS-1:0]}} : wr_data;
        rd_sel   = rd_raw[{rd_off, 3'b000} +: LANE_BITS];
        rd_data  = rd_byte ? {{(32-LANE_BITS){1'b0}}, rd_sel} : rd_raw;
    end

endmodule

// File: rtl/lsu_mem.sv
// Memory-stage load/store unit: turns datapath load/store requests into a
// single-outstanding bus access with stall, misalignment and timeout handling.
module lsu_mem
    import lsu_mem_pkg::*;
#(
    parameter int          TIMEOUT = 16,
    parameter logic [31:0] ERRDATA = 32'hDEADBEEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        ByteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_t    state;
    logic [CW-1:0] busy_cnt;

    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          we_q;
    logic          byte_q;
    logic [31:0]   rdata_q;

    logic          access;
    logic          aligned;
    logic          accept;
    logic          complete;
    logic          timeout_hit;

    logic [3:0]    lane_be_w;
    logic [31:0]   lane_wdata;
    logic [31:0]   lane_rdata;

    // Reset gates the IDLE decodes so nothing is stalled or flagged while reset is held.
    assign access      = MemReadM | MemWriteM;
    assign aligned     = ByteM | (ALUOutM[1:0] == 2'b00);
    assign accept      = (state == IDLE) & access & aligned & ~reset;
    assign complete    = (state == BUSY) & bus_ready;
    assign timeout_hit = (state == BUSY) & ~bus_ready & (busy_cnt == CNT_LAST);

    lsu_lane u_lane (
        .wr_byte  (ByteM),
        .wr_off   (ALUOutM[1:0]),
        .wr_data  (WriteDataM),
        .be       (lane_be_w),
        .wr_lanes (lane_wdata),
        .rd_byte  (byte_q),
        .rd_off   (addr_q[1:0]),
        .rd_raw   (bus_rdata),
        .rd_data  (lane_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept) state <= BUSY;
                BUSY:    if (complete | timeout_hit) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
        end else if (state != BUSY || complete || timeout_hit) begin
            busy_cnt <= '0;
        end else begin
            busy_cnt <= busy_cnt + CW'(1);
        end
    end

    // Request latch: holds the bus-side view of the access stable for the whole BUSY phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
        end else if (accept) begin
            addr_q  <= ALUOutM;
            wdata_q <= lane_wdata;
            be_q    <= lane_be_w;
            we_q    <= MemWriteM;
            byte_q  <= ByteM;
        end
    end

    // Completion wins over timeout; stores never touch the load-data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (complete) begin
            if (!we_q) rdata_q <= lane_rdata;
        end else if (timeout_hit) begin
            rdata_q <= ERRDATA;
        end
    end

    assign StallM    = accept | (state == BUSY);
    assign MisalignM = (state == IDLE) & access & ~aligned & ~reset;
    assign BusErrM   = timeout_hit;

    assign bus_req   = (state == BUSY);
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign ReadDataM = rdata_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Self-checking bench for lsu_mem: vector table with a load-data scoreboard,
// plus hand sequences for back-to-back accesses and reset during BUSY.
module tb_lsu_mem;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic        ByteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        BusErrM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    lsu_mem #(.TIMEOUT(TO), .ERRDATA(ERR)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ByteM      (ByteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic        byt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        misalign;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic byt,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        MemReadM   = rd;
        MemWriteM  = wr;
        ByteM      = byt;
        ALUOutM    = addr;
        WriteDataM = wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic runVector(input int idx);
        vec_t v;
        int   nb;
        int   stalls;
        v = vecs[idx];
        bus_rdata = v.rdata;
        bus_ready = 1'b0;
        applyStimulus(v.rd, v.wr, v.byt, v.addr, v.wdata);
        @(negedge clk);
        if (v.misalign) begin
            checkOutput($sformatf("v%0d_misalign", idx), MisalignM, 1);
            checkOutput($sformatf("v%0d_mis_stall", idx), StallM, 0);
            checkOutput($sformatf("v%0d_mis_req", idx), bus_req, 0);
            step();
            applyStimulus(0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput($sformatf("v%0d_mis_clear", idx), MisalignM, 0);
            checkOutput($sformatf("v%0d_mis_req2", idx), bus_req, 0);
            checkOutput($sformatf("v%0d_mis_rdata", idx), ReadDataM, v.exp_rd);
            step();
            return;
        end
        checkOutput($sformatf("v%0d_accept_stall", idx), StallM, 1);
        checkOutput($sformatf("v%0d_accept_req", idx), bus_req, 0);
        checkOutput($sformatf("v%0d_accept_mis", idx), MisalignM, 0);
        stalls = int'(StallM);
        exp_q.push_back(v.exp_rd);
        nb = (v.delay < TO) ? v.delay + 1 : TO;
        step();
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < nb; i++) begin
            bus_ready = (i == v.delay);
            @(negedge clk);
            stalls += int'(StallM);
            checkOutput($sformatf("v%0d_c%0d_req", idx, i), bus_req, 1);
            checkOutput($sformatf("v%0d_c%0d_addr", idx, i), bus_addr, v.exp_addr);
            checkOutput($sformatf("v%0d_c%0d_we", idx, i), bus_we, v.exp_we);
            checkOutput($sformatf("v%0d_c%0d_wdata", idx, i), bus_wdata, v.exp_wdata);
            if (v.exp_we || !v.byt)
                checkOutput($sformatf("v%0d_c%0d_be", idx, i), bus_be, v.exp_be);
            checkOutput($sformatf("v%0d_c%0d_buserr", idx, i), BusErrM,
                        (v.delay >= TO) && (i == TO - 1));
            step();
        end
        bus_ready = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("v%0d_done_req", idx), bus_req, 0);
        checkOutput($sformatf("v%0d_done_stall", idx), StallM, 0);
        checkOutput($sformatf("v%0d_done_buserr", idx), BusErrM, 0);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL v%0d_scoreboard: got empty queue, want one entry", idx);
        end else begin
            checkOutput($sformatf("v%0d_readdata", idx), ReadDataM, exp_q.pop_front());
        end
        checkOutput($sformatf("v%0d_stall_cycles", idx), stalls, 1 + nb);
        step();
    endtask

    logic [5:0] b2b_req;
    logic [5:0] b2b_stall;

    initial begin
        // rd, wr, byt, addr, wdata, rdata, delay, misalign, exp_addr, exp_be, exp_wdata, exp_we, exp_rd
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        32'h12345678, 0, 1'b0, 32'h100, 4'hF, 32'h0,        1'b0, 32'h12345678};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h203, 32'hAB,       32'h0,        0, 1'b0, 32'h200, 4'h8, 32'hABABABAB, 1'b1, 32'h12345678};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h102, 32'h0,        32'h0,        0, 1'b1, 32'h0,   4'h0, 32'h0,        1'b0, 32'h12345678};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h301, 32'h0,        32'hA1B2C3D4, 1, 1'b0, 32'h300, 4'h2, 32'h0,        1'b0, 32'h000000C3};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h404, 32'hCAFEF00D, 32'h0,        2, 1'b0, 32'h404, 4'hF, 32'hCAFEF00D, 1'b1, 32'h000000C3};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h500, 32'h0,        32'h0,        9, 1'b0, 32'h500, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h603, 32'h0,        32'h89ABCDEF, 3, 1'b0, 32'h600, 4'h8, 32'h0,        1'b0, 32'h00000089};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h700, 32'h11223344, 32'h0,        0, 1'b0, 32'h700, 4'hF, 32'h11223344, 1'b1, 32'h00000089};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h802, 32'h0,        32'h55667788, 0, 1'b0, 32'h800, 4'h4, 32'h0,        1'b0, 32'h00000066};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h900, 32'h12345677, 32'h0,        1, 1'b0, 32'h900, 4'h1, 32'h77777777, 1'b1, 32'h00000066};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'hA0A, 32'h55,       32'h0,        0, 1'b1, 32'h0,   4'h0, 32'h0,        1'b0, 32'h00000066};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'hB04, 32'h0F0F0F0F, 32'h0,        9, 1'b0, 32'hB04, 4'hF, 32'h0F0F0F0F, 1'b1, 32'hDEADBEEF};

        // Cycle-by-cycle expectations for load then store with bus_ready held high.
        b2b_req   = 6'b010010;
        b2b_stall = 6'b011011;

        reset     = 1'b1;
        bus_ready = 1'b0;
        bus_rdata = '0;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req", bus_req, 0);
        checkOutput("rst_stall", StallM, 0);
        checkOutput("rst_rdata", ReadDataM, 32'h0);
        checkOutput("rst_mis", MisalignM, 0);
        checkOutput("rst_buserr", BusErrM, 0);
        checkOutput("rst_addr", bus_addr, 32'h0);
        checkOutput("rst_be", bus_be, 4'h0);
        checkOutput("rst_we", bus_we, 0);
        reset = 1'b0;
        step();

        for (int k = 0; k < 12; k++) runVector(k);

        bus_ready = 1'b1;
        bus_rdata = 32'h0BADF00D;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) applyStimulus(1, 0, 0, 32'h100, 32'h0);
            if (c == 2) applyStimulus(0, 1, 0, 32'h104, 32'h5A5A5A5A);
            if (c == 4) applyStimulus(0, 0, 0, 32'h0, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("b2b_c%0d_req", c), bus_req, b2b_req[c]);
            checkOutput($sformatf("b2b_c%0d_stall", c), StallM, b2b_stall[c]);
            if (c == 1) checkOutput("b2b_load_we", bus_we, 0);
            if (c == 4) checkOutput("b2b_store_we", bus_we, 1);
            if (c == 4) checkOutput("b2b_store_addr", bus_addr, 32'h104);
            if (c == 2 || c == 5) checkOutput($sformatf("b2b_c%0d_rdata", c), ReadDataM, 32'h0BADF00D);
            step();
        end
        bus_ready = 1'b0;

        bus_rdata = 32'h77777777;
        applyStimulus(1, 0, 0, 32'hA00, 32'h0);
        step();
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        step();
        reset = 1'b1;
        #1;
        checkOutput("rstbusy_req", bus_req, 0);
        checkOutput("rstbusy_stall", StallM, 0);
        checkOutput("rstbusy_rdata", ReadDataM, 32'h0);
        checkOutput("rstbusy_buserr", BusErrM, 0);
        @(negedge clk);
        reset     = 1'b0;
        bus_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rstbusy_after%0d_req", c), bus_req, 0);
            checkOutput($sformatf("rstbusy_after%0d_stall", c), StallM, 0);
            checkOutput($sformatf("rstbusy_after%0d_rdata", c), ReadDataM, 32'h0);
        end
        bus_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
